spike_arbiter: RTL and testbench
================================

SPIKE_ARBITER -- requirements
Module: spike_arbiter

Interface
REQ-001 Parameter N_NEURONS, default 16, number of neuron output_spike inputs arbitrated.
REQ-002 Parameter ADDR_WIDTH, default $clog2(N_NEURONS), width of emitted neuron address.
REQ-003 Parameter TS_WIDTH, default 16, timestamp width (used only with SPIKE_TIMESTAMP_EN).
REQ-004 Parameter DROP_WIDTH, default 8, width of saturating drop counter.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock, shared with neurons.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 spike_in  input  N_NEURONS  one-cycle spike pulses, bit i from neuron i.
REQ-009 out_valid  output  1  spike event available.
REQ-010 out_ready  input  1  consumer accepts event when high with out_valid.
REQ-011 out_addr  output  ADDR_WIDTH  index of spiking neuron.
REQ-012 out_timestamp  output  TS_WIDTH  capture time of event (present only with SPIKE_TIMESTAMP_EN).
REQ-013 drop_count  output  DROP_WIDTH  number of spikes lost to an already-pending slot.

Function
REQ-014 Per-neuron pending bit set at the clock edge where spike_in[i]=1.
REQ-015 Output stage is a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 EMPTY -> FULL when any pending bit set: load winner address, clear winner pending bit, same edge.
REQ-017 FULL -> FULL with new winner when out_ready=1 and pending nonzero (back-to-back, no bubble).
REQ-018 FULL -> EMPTY when out_ready=1 and no pending bit set.
REQ-019 FULL with out_ready=0: out_addr/out_timestamp held stable, no pending bit cleared.
REQ-020 Winner is round-robin: first set pending bit strictly after the last granted index, wrapping N_NEURONS-1 -> 0; after reset search starts at index 0.
REQ-021 Latency: spike_in[i] high in cycle c, output EMPTY, no competitors -> out_valid=1, out_addr=i in cycle c+2.
REQ-022 spike_in[i]=1 while pending[i]=1 and i not granted that edge -> spike dropped, drop_count +1.
REQ-023 spike_in[i]=1 on the edge pending[i] is granted -> pending[i] remains set (new event), no drop.
REQ-024 Multiple drops same cycle increment drop_count by the number dropped; drop_count saturates at all-ones.
REQ-025 Each neuron's pending events are delivered in arrival order; no event is ever emitted twice.

Reset
REQ-026 On reset: out_valid=0, out_addr=0, out_timestamp=0, drop_count=0, all pending bits 0, round-robin pointer so next search begins at 0, timestamp counter 0.
REQ-027 Reset asserted mid-handshake discards the held event and all pending events; no event emitted in first cycle after deassertion.

Configuration
REQ-028 Macro SPIKE_TIMESTAMP_EN defined: free-running TS_WIDTH counter increments every clk, wraps modulo 2^TS_WIDTH; per-neuron timestamp register captures counter value on the edge pending[i] is set; value forwarded to out_timestamp with the address.
REQ-029 Macro SPIKE_TIMESTAMP_EN undefined: no counter, no timestamp registers, no out_timestamp port; all other behaviour identical.

Structure
REQ-030 Shared package spike_pkg holds typedef spike_event_t (addr, optional timestamp) and default constants N_NEURONS, TS_WIDTH, DROP_WIDTH.
REQ-031 Round-robin selection lives in sub-module rr_arbiter (pure combinational: request vector, last-grant pointer -> one-hot grant, grant index, any_grant).

Verification
REQ-032 Single spike_in[5] pulse cycle 10, out_ready=1 -> out_valid cycle 12, out_addr=5, one cycle only.
REQ-033 spike_in=0x0009 one cycle, out_ready=1 -> events addr 0 then 3 in consecutive cycles, next round starts after 3.
REQ-034 All 16 bits pulse simultaneously, out_ready=0 for 20 cycles then 1 -> addr 0 held stable 20 cycles, then 0..15 delivered back-to-back, drop_count=0.
REQ-035 spike_in[2] pulsed 3 times while out_ready=0 and output holds addr 7 -> drop_count=2, exactly one addr-2 event later.
REQ-036 With SPIKE_TIMESTAMP_EN, TS_WIDTH=4: spike_in[1] at counter 15, spike_in[1] again after wrap at counter 2 -> timestamps 15 then 2.
REQ-037 Reset asserted while out_valid=1 and 4 pending -> out_valid drops asynchronously, no stale event emitted after release.

Source files
------------

// File: rtl/spike_pkg.sv
// spike_pkg: shared types and default constants for the spike arbiter slice.
// Optional feature macro: SPIKE_TIMESTAMP_EN adds a timestamp field to
// spike_event_t (and a timestamp path in spike_arbiter).
// No ports (package).
package spike_pkg;

  localparam int N_NEURONS  = 16;
  localparam int TS_WIDTH   = 16;
  localparam int DROP_WIDTH = 8;
  localparam int ADDR_WIDTH = $clog2(N_NEURONS);

  // One emitted spike event at default sizing.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
`ifdef SPIKE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]   timestamp;
`endif
  } spike_event_t;

endpackage

// File: rtl/spike_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin selector.
// Ports:
//   req       in  N_REQ  request vector
//   last_idx  in  IDX_W  index granted most recently
//   grant     out N_REQ  one-hot grant
//   grant_idx out IDX_W  index of the granted request
//   any_grant out 1      some request was granted
// The search begins one past last_idx and wraps N_REQ-1 -> 0.
module rr_arbiter #(
  parameter int N_REQ = 16,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);
  import spike_pkg::*;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // off = N_REQ wraps back to last_idx itself, so it is checked last.
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_idx) + off) % N_REQ;
      if (!any_grant && req[idx[IDX_W-1:0]]) begin
        grant[idx[IDX_W-1:0]] = 1'b1;
        grant_idx             = idx[IDX_W-1:0];
        any_grant             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_arbiter.sv
// spike_arbiter: collects one-cycle neuron spike pulses into per-neuron
// pending bits and serialises them onto a valid/ready event stream,
// choosing between pending neurons round-robin.
// Optional feature macro: SPIKE_TIMESTAMP_EN (free-running timestamp counter,
// per-neuron capture registers and the out_timestamp port).
// Ports:
//   clk            in  1           system clock
//   reset          in  1           asynchronous active-high reset
//   spike_in       in  N_NEURONS   spike pulses, bit i from neuron i
//   out_valid      out 1           event available
//   out_ready      in  1           consumer accepts event
//   out_addr       out ADDR_WIDTH  index of spiking neuron
//   out_timestamp  out TS_WIDTH    capture time (SPIKE_TIMESTAMP_EN only)
//   drop_count     out DROP_WIDTH  saturating count of lost spikes
//
// Output stage states:
//   state | meaning
//   EMPTY | no event held, out_valid=0
//   FULL  | event held in out_addr/out_timestamp, out_valid=1
module spike_arbiter #(
  parameter int N_NEURONS  = spike_pkg::N_NEURONS,
  parameter int ADDR_WIDTH = $clog2(N_NEURONS),
  parameter int TS_WIDTH   = spike_pkg::TS_WIDTH,
  parameter int DROP_WIDTH = spike_pkg::DROP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_NEURONS-1:0]  spike_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
`ifdef SPIKE_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]   out_timestamp,
`endif
  output logic [DROP_WIDTH-1:0] drop_count
);
  import spike_pkg::*;

  localparam int SUM_W = DROP_WIDTH + ADDR_WIDTH + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state;
  logic [N_NEURONS-1:0]  pending;
  logic [N_NEURONS-1:0]  grant;
  logic [N_NEURONS-1:0]  clear_vec;
  logic [N_NEURONS-1:0]  drop_vec;
  logic [ADDR_WIDTH-1:0] last_ptr;
  logic [ADDR_WIDTH-1:0] grant_idx;
  logic                  any_grant;
  logic                  take;
  logic                  fire;
  logic [SUM_W-1:0]      drop_sum;

  rr_arbiter #(
    .N_REQ (N_NEURONS),
    .IDX_W (ADDR_WIDTH)
  ) u_rr (
    .req       (pending),
    .last_idx  (last_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // The output slot can take a new event when empty or being drained.
  assign take      = (state == EMPTY) || out_ready;
  assign fire      = take && any_grant;
  assign clear_vec = fire ? grant : '0;
  // A spike on the edge its own pending bit is granted is a fresh event,
  // not a drop.
  assign drop_vec  = spike_in & pending & ~clear_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clear_vec) | spike_in;
    end
  end

  always_comb begin
    drop_sum = SUM_W'(drop_count);
    for (int i = 0; i < N_NEURONS; i++) begin
      drop_sum = drop_sum + SUM_W'(drop_vec[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_sum > SUM_W'({DROP_WIDTH{1'b1}})) begin
      drop_count <= '1;
    end else begin
      drop_count <= drop_sum[DROP_WIDTH-1:0];
    end
  end

`ifdef SPIKE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]  ts_cnt;
  logic [TS_WIDTH-1:0]  ts_reg [N_NEURONS];
  logic [N_NEURONS-1:0] accept_vec;

  assign accept_vec = spike_in & ~drop_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt <= '0;
      for (int i = 0; i < N_NEURONS; i++) ts_reg[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      for (int i = 0; i < N_NEURONS; i++) begin
        if (accept_vec[i]) ts_reg[i] <= ts_cnt;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_addr  <= '0;
      // Pointing at the last index makes the first search start at 0.
      last_ptr  <= ADDR_WIDTH'(N_NEURONS - 1);
`ifdef SPIKE_TIMESTAMP_EN
      out_timestamp <= '0;
`endif
    end else if (take) begin
      if (any_grant) begin
        state     <= FULL;
        out_valid <= 1'b1;
        out_addr  <= grant_idx;
        last_ptr  <= grant_idx;
`ifdef SPIKE_TIMESTAMP_EN
        out_timestamp <= ts_reg[grant_idx];
`endif
      end else begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_arbiter.sv
module tb_spike_arbiter;

`ifdef SPIKE_TIMESTAMP_EN
  localparam int TSW = 4;
`else
  localparam int TSW = 16;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] spike_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_addr;
  logic [7:0]  drop_count;
`ifdef SPIKE_TIMESTAMP_EN
  logic [TSW-1:0] out_timestamp;
`endif

  int checks = 0;
  int errors = 0;

  spike_arbiter #(
    .N_NEURONS  (16),
    .ADDR_WIDTH (4),
    .TS_WIDTH   (TSW),
    .DROP_WIDTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .spike_in      (spike_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
`ifdef SPIKE_TIMESTAMP_EN
    .out_timestamp (out_timestamp),
`endif
    .drop_count    (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    reset     = 1'b1;
    spike_in  = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_addr !== 4'd0) begin
      errors++; $display("FAIL reset_addr: got %0d expected 0", out_addr);
    end
    checks++;
    if (drop_count !== 8'd0) begin
      errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    spike_in  = 16'h0020;
    @(negedge clk);
    spike_in = '0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_c1_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd5) begin
      errors++; $display("FAIL single_c2: got valid=%b addr=%0d expected valid=1 addr=5", out_valid, out_addr);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_c3_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a [4];
    exp_a[0] = 4'd0; exp_a[1] = 4'd3; exp_a[2] = 4'd4; exp_a[3] = 4'd0;
    out_ready = 1'b1;
    spike_in  = 16'h0009;
    @(negedge clk);
    spike_in = '0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_addr !== exp_a[i]) begin
        errors++; $display("FAIL rr_first[%0d]: got valid=%b addr=%0d expected valid=1 addr=%0d", i, out_valid, out_addr, exp_a[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rr_gap_valid: got %b expected 0", out_valid);
    end
    spike_in = 16'h0011;
    @(negedge clk);
    spike_in = '0;
    @(negedge clk);
    for (int i = 2; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_addr !== exp_a[i]) begin
        errors++; $display("FAIL rr_second[%0d]: got valid=%b addr=%0d expected valid=1 addr=%0d", i, out_valid, out_addr, exp_a[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rr_end_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    spike_in  = 16'hFFFF;
    @(negedge clk);
    spike_in = '0;
    @(negedge clk);
    for (int j = 0; j < 20; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 4'd0) begin
        errors++; $display("FAIL b2b_hold[%0d]: got valid=%b addr=%0d expected valid=1 addr=0", j, out_valid, out_addr);
      end
      if (j == 19) out_ready = 1'b1;
      @(negedge clk);
    end
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 4'(i)) begin
        errors++; $display("FAIL b2b_seq[%0d]: got valid=%b addr=%0d expected valid=1 addr=%0d", i, out_valid, out_addr, i);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (drop_count !== 8'd0) begin
      errors++; $display("FAIL b2b_drop: got %0d expected 0", drop_count);
    end
  endtask

  task automatic test_drop();
    int n2;
    int nev;
    n2  = 0;
    nev = 0;
    do_reset();
    out_ready = 1'b0;
    spike_in  = 16'h0080;
    @(negedge clk);
    spike_in = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd7) begin
      errors++; $display("FAIL drop_hold7: got valid=%b addr=%0d expected valid=1 addr=7", out_valid, out_addr);
    end
    for (int k = 0; k < 3; k++) begin
      spike_in = 16'h0004;
      @(negedge clk);
      spike_in = '0;
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd7) begin
      errors++; $display("FAIL drop_still7: got valid=%b addr=%0d expected valid=1 addr=7", out_valid, out_addr);
    end
    checks++;
    if (drop_count !== 8'd2) begin
      errors++; $display("FAIL drop_count: got %0d expected 2", drop_count);
    end
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) nev++;
      if (out_valid && out_addr == 4'd2) n2++;
    end
    checks++;
    if (n2 !== 1 || nev !== 1) begin
      errors++; $display("FAIL drop_events: got addr2=%0d total=%0d expected addr2=1 total=1", n2, nev);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    spike_in  = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (drop_count !== 8'd0) begin
      errors++; $display("FAIL sat_e1: got %0d expected 0", drop_count);
    end
    @(negedge clk);
    checks++;
    if (drop_count !== 8'd15) begin
      errors++; $display("FAIL sat_e2_granted_no_drop: got %0d expected 15", drop_count);
    end
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd0) begin
      errors++; $display("FAIL sat_e2_out: got valid=%b addr=%0d expected valid=1 addr=0", out_valid, out_addr);
    end
    @(negedge clk);
    checks++;
    if (drop_count !== 8'd31) begin
      errors++; $display("FAIL sat_e3: got %0d expected 31", drop_count);
    end
    repeat (17) @(negedge clk);
    checks++;
    if (drop_count !== 8'd255) begin
      errors++; $display("FAIL sat_full: got %0d expected 255", drop_count);
    end
    spike_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (drop_count !== 8'd255) begin
      errors++; $display("FAIL sat_stay: got %0d expected 255", drop_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    spike_in  = 16'h003E;
    @(negedge clk);
    spike_in = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd1) begin
      errors++; $display("FAIL rstmid_pre: got valid=%b addr=%0d expected valid=1 addr=1", out_valid, out_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got %b expected 0", out_valid);
    end
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_after[%0d]: got %b expected 0", k, out_valid);
      end
    end
    checks++;
    if (drop_count !== 8'd0) begin
      errors++; $display("FAIL rstmid_drop: got %0d expected 0", drop_count);
    end
  endtask

`ifdef SPIKE_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    spike_in = 16'h0002;
    @(negedge clk);
    spike_in = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd1 || out_timestamp !== 4'd15) begin
      errors++; $display("FAIL ts_first: got valid=%b addr=%0d ts=%0d expected valid=1 addr=1 ts=15", out_valid, out_addr, out_timestamp);
    end
    @(negedge clk);
    spike_in = 16'h0002;
    @(negedge clk);
    spike_in = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd1 || out_timestamp !== 4'd2) begin
      errors++; $display("FAIL ts_wrap: got valid=%b addr=%0d ts=%0d expected valid=1 addr=1 ts=2", out_valid, out_addr, out_timestamp);
    end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    spike_in  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_drop();
    test_saturation();
    test_reset_mid();
`ifdef SPIKE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
